sram64kb_ctrl: RTL and testbench
================================

Name: sram64kb_ctrl

Overview:
Request-side controller that drives the 64 KB banked SRAM array (64 banks of 1024x8 macros). It accepts byte read and write requests over a valid/ready interface and splits each 16-bit byte address into a bank select and a row address. It generates the macro strobe (MEM_CE) and the active-low per-bank chip and output enables, then captures the muxed read byte. It sits between the bus-side memory controller logic and the SRAM64KB array.

Parameters:
NUM_BANKS, 64, number of 1024x8 banks; fixed at 64 for this array.
BANK_AW, 10, row address width inside one bank.
DATA_W, 8, data width.
ACCESS_WAIT, 1, cycles between the MEM_CE rising edge and read-data capture. Legal range is 1..15.

Ports:
CLK  input  1  system clock; the only clock in the block.
RST  input  1  synchronous, active-high reset.
REQ_VALID  input  1  request present.
REQ_READY  output  1  controller can accept a request; high only in IDLE and RST low.
REQ_WRITE  input  1  1 = write, 0 = read.
REQ_ADDR  input  16  byte address; [15:10] = bank, [9:0] = row.
REQ_WDATA  input  8  write byte.
RSP_VALID  output  1  one-cycle completion pulse for both reads and writes.
RSP_RDATA  output  8  read byte; holds its value until the next read completes.
MEM_ADDR  output  10  row address to all banks.
MEM_CE  output  1  macro strobe; array latches on its rising edge.
MEM_WEB  output  1  active-low write enable.
MEM_OEB  output  64  active-low output enable, one bit per bank.
MEM_CSB  output  64  active-low chip select, one bit per bank.
MEM_IDATA  output  8  write data to the array.
MEM_ODATA_SELECT  output  6  bank select for the array read mux.
MEM_ODATA  input  8  muxed read data from the array.

Behaviour:
- All outputs are registered except REQ_READY, which is defined as (state==IDLE) & ~RST.
- Reset values:
  - MEM_CSB = all ones; MEM_OEB = all ones; MEM_WEB = 1; MEM_CE = 0.
  - MEM_ADDR = 0; MEM_IDATA = 0; MEM_ODATA_SELECT = 0.
  - RSP_VALID = 0; RSP_RDATA = 0; state = IDLE; wait counter = 0.
- Handshake: a request is accepted at a rising edge where REQ_VALID & REQ_READY. Call that edge k.
  - Address, write flag and write data are latched at edge k.
  - REQ_* inputs are ignored after that.
  - REQ_VALID is not required to stay high.
- FSM, one state per cycle unless noted:
  - IDLE: all strobes inactive. On handshake, go to SETUP.
  - SETUP (cycle k+1):
    - MEM_ADDR = row; MEM_ODATA_SELECT = bank; MEM_CSB[bank] = 0, all other bits 1.
    - Read: MEM_OEB[bank] = 0, MEM_WEB = 1.
    - Write: MEM_OEB all ones, MEM_WEB = 0, MEM_IDATA = wdata.
    - MEM_CE = 0. Go to STROBE.
  - STROBE (k+2): MEM_CE = 1; all other memory outputs are held. Go to WAIT and load the counter with ACCESS_WAIT-1.
  - WAIT (k+3 .. k+2+ACCESS_WAIT): MEM_CE = 0; MEM_WEB returns to 1; CSB, OEB, ADDR and SELECT are held. Decrement the counter; at 0, go to RESP.
    - Read: MEM_ODATA is sampled into RSP_RDATA at the edge leaving the last WAIT cycle.
  - RESP (k+3+ACCESS_WAIT): RSP_VALID = 1 for exactly one cycle. MEM_CSB and MEM_OEB return to all ones. Go to IDLE.
- Latency: accept to RSP_VALID is 3+ACCESS_WAIT cycles. Throughput is one access per 4+ACCESS_WAIT cycles; there is no pipelining.
- Write cycles leave RSP_RDATA unchanged.
- At most one MEM_CSB bit and at most one MEM_OEB bit may be low at any time. MEM_OEB must never be low while MEM_WEB is low.
- Address boundaries:
  - 0xFFFF → bank 63, row 1023.
  - 0x03FF → bank 0, row 1023.
  - 0x0400 → bank 1, row 0.
- REQ_VALID held high outside IDLE has no effect.
- RST asserted in any state: at the next edge, all outputs take their reset values and the FSM goes to IDLE. No RSP_VALID is issued for the aborted access.
  - A write aborted before STROBE must not reach the array.
  - A write aborted after STROBE is already committed.
- RST and REQ_VALID high together: the request is not accepted.

Decomposition:
- Package sram64kb_pkg:
  - constants NUM_BANKS, BANK_AW, BANK_SEL_W (=6), DATA_W;
  - state encoding (IDLE, SETUP, STROBE, WAIT, RESP);
  - the all-ones 64-bit deselect constant.
- Sub-module sram_bank_dec: inputs bank[5:0] and en; output 64-bit active-low one-hot. Instantiated twice, once for CSB and once for OEB (with en = read).

Test Plan:
1. Write 0xA5 to 0x0000, then read 0x0000 → RSP_RDATA = 0xA5, RSP_VALID 4 cycles after the accept edge (ACCESS_WAIT=1), MEM_CSB = ~64'h1 during the access.
2. Write 0x3C to 0xFFFF and 0xC3 to 0x03FF, then read both → MEM_ODATA_SELECT = 63 / 0, MEM_ADDR = 1023; data 0x3C / 0xC3.
3. Read 0x0400 → MEM_ODATA_SELECT = 1, MEM_ADDR = 0, MEM_OEB = ~64'h2; during the write phase of any write, MEM_OEB = all ones.
4. REQ_VALID held high for 3 back-to-back reads → REQ_READY low for cycles k+1..k+4; accepts spaced 5 cycles apart; exactly 3 RSP_VALID pulses.
5. RST asserted during a WAIT cycle of a read → next cycle: CSB/OEB all ones, MEM_CE 0, no RSP_VALID, REQ_READY 1 the cycle after RST drops.
6. ACCESS_WAIT=3, read a stored 0x5A → MEM_CE high for exactly 1 cycle, RSP_VALID at k+6, RSP_RDATA = 0x5A.

Source files
------------

// File: rtl/sram64kb_pkg.sv
// Shared constants, state encoding and request payload for the 64 KB banked SRAM controller.
package sram64kb_pkg;

    localparam int unsigned NUM_BANKS  = 64;
    localparam int unsigned BANK_AW    = 10;
    localparam int unsigned BANK_SEL_W = 6;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned ADDR_W     = BANK_SEL_W + BANK_AW;
    localparam int unsigned WAIT_W     = 4;

    localparam logic [NUM_BANKS-1:0] BANK_DESELECT = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic                  write;
        logic [BANK_SEL_W-1:0] bank;
        logic [BANK_AW-1:0]    row;
        logic [DATA_W-1:0]     wdata;
    } req_t;

endpackage

// File: rtl/sram_bank_dec.sv
// Bank number to active-low one-hot select; all ones when disabled.
module sram_bank_dec
    import sram64kb_pkg::*;
(
    input  logic [BANK_SEL_W-1:0] bank,
    input  logic                  en,
    output logic [NUM_BANKS-1:0]  sel_n_c
);

    always_comb begin
        sel_n_c = BANK_DESELECT;
        if (en) begin
            sel_n_c[bank] = 1'b0;
        end
    end

endmodule

// File: rtl/sram64kb_ctrl.sv
// Request-side controller for the 64-bank SRAM array: one byte access at a time,
// setup / strobe / wait / respond sequencing with registered macro controls.
module sram64kb_ctrl
    import sram64kb_pkg::*;
#(
    parameter int unsigned ACCESS_WAIT = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_WRITE,
    input  logic [ADDR_W-1:0]     REQ_ADDR,
    input  logic [DATA_W-1:0]     REQ_WDATA,
    output logic                  RSP_VALID,
    output logic [DATA_W-1:0]     RSP_RDATA,
    output logic [BANK_AW-1:0]    MEM_ADDR,
    output logic                  MEM_CE,
    output logic                  MEM_WEB,
    output logic [NUM_BANKS-1:0]  MEM_OEB,
    output logic [NUM_BANKS-1:0]  MEM_CSB,
    output logic [DATA_W-1:0]     MEM_IDATA,
    output logic [BANK_SEL_W-1:0] MEM_ODATA_SELECT,
    input  logic [DATA_W-1:0]     MEM_ODATA
);

    state_t                state_q, state_d;
    logic [WAIT_W-1:0]     cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    req_t                  req_c;
    logic                  hs_c;
    logic [NUM_BANKS-1:0]  csb_dec_c, oeb_dec_c;

    logic                  rsp_valid_d;
    logic [DATA_W-1:0]     rsp_rdata_d;
    logic [BANK_AW-1:0]    mem_addr_d;
    logic                  mem_ce_d;
    logic                  mem_web_d;
    logic [NUM_BANKS-1:0]  mem_oeb_d;
    logic [NUM_BANKS-1:0]  mem_csb_d;
    logic [DATA_W-1:0]     mem_idata_d;
    logic [BANK_SEL_W-1:0] mem_sel_d;

    assign REQ_READY = (state_q == ST_IDLE) & ~RST;
    assign hs_c      = REQ_VALID & REQ_READY;

    assign req_c.write = REQ_WRITE;
    assign req_c.bank  = REQ_ADDR[ADDR_W-1:BANK_AW];
    assign req_c.row   = REQ_ADDR[BANK_AW-1:0];
    assign req_c.wdata = REQ_WDATA;

    // Selects are decoded from the incoming request so they are live in SETUP.
    sram_bank_dec u_csb_dec (
        .bank    (req_c.bank),
        .en      (hs_c),
        .sel_n_c (csb_dec_c)
    );

    sram_bank_dec u_oeb_dec (
        .bank    (req_c.bank),
        .en      (hs_c & ~req_c.write),
        .sel_n_c (oeb_dec_c)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q          <= ST_IDLE;
            cnt_q            <= '0;
            wr_q             <= 1'b0;
            RSP_VALID        <= 1'b0;
            RSP_RDATA        <= '0;
            MEM_ADDR         <= '0;
            MEM_CE           <= 1'b0;
            MEM_WEB          <= 1'b1;
            MEM_OEB          <= BANK_DESELECT;
            MEM_CSB          <= BANK_DESELECT;
            MEM_IDATA        <= '0;
            MEM_ODATA_SELECT <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            wr_q             <= wr_d;
            RSP_VALID        <= rsp_valid_d;
            RSP_RDATA        <= rsp_rdata_d;
            MEM_ADDR         <= mem_addr_d;
            MEM_CE           <= mem_ce_d;
            MEM_WEB          <= mem_web_d;
            MEM_OEB          <= mem_oeb_d;
            MEM_CSB          <= mem_csb_d;
            MEM_IDATA        <= mem_idata_d;
            MEM_ODATA_SELECT <= mem_sel_d;
        end
    end

    // Next state and next registered outputs; outputs reflect the state being entered.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = RSP_RDATA;
        mem_addr_d  = MEM_ADDR;
        mem_ce_d    = 1'b0;
        mem_web_d   = MEM_WEB;
        mem_oeb_d   = MEM_OEB;
        mem_csb_d   = MEM_CSB;
        mem_idata_d = MEM_IDATA;
        mem_sel_d   = MEM_ODATA_SELECT;

        unique case (state_q)
            ST_IDLE: begin
                if (hs_c) begin
                    state_d    = ST_SETUP;
                    wr_d       = req_c.write;
                    mem_addr_d = req_c.row;
                    mem_sel_d  = req_c.bank;
                    mem_csb_d  = csb_dec_c;
                    mem_oeb_d  = oeb_dec_c;
                    mem_web_d  = ~req_c.write;
                    if (req_c.write) begin
                        mem_idata_d = req_c.wdata;
                    end
                end
            end
            ST_SETUP: begin
                state_d  = ST_STROBE;
                mem_ce_d = 1'b1;
            end
            ST_STROBE: begin
                state_d   = ST_WAIT;
                cnt_d     = WAIT_W'(ACCESS_WAIT - 1);
                mem_web_d = 1'b1;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    mem_csb_d   = BANK_DESELECT;
                    mem_oeb_d   = BANK_DESELECT;
                    if (!wr_q) begin
                        rsp_rdata_d = MEM_ODATA;
                    end
                end else begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sram64kb_ctrl.sv
// Directed bench for sram64kb_ctrl with behavioural SRAM array models.
module tb_sram64kb_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Instance with ACCESS_WAIT = 1
    logic        req_valid, req_ready, req_write;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic [9:0]  mem_addr;
    logic        mem_ce, mem_web;
    logic [63:0] mem_oeb, mem_csb;
    logic [7:0]  mem_idata, mem_odata;
    logic [5:0]  mem_sel;

    // Instance with ACCESS_WAIT = 3
    logic        b_valid, b_ready, b_write;
    logic [15:0] b_addr;
    logic [7:0]  b_wdata;
    logic        b_rsp;
    logic [7:0]  b_rdata;
    logic [9:0]  b_maddr;
    logic        b_ce, b_web;
    logic [63:0] b_oeb, b_csb;
    logic [7:0]  b_idata, b_odata;
    logic [5:0]  b_sel;

    sram64kb_ctrl #(.ACCESS_WAIT(1)) dut (
        .CLK(clk), .RST(rst), .REQ_VALID(req_valid), .REQ_READY(req_ready),
        .REQ_WRITE(req_write), .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
        .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata), .MEM_ADDR(mem_addr),
        .MEM_CE(mem_ce), .MEM_WEB(mem_web), .MEM_OEB(mem_oeb), .MEM_CSB(mem_csb),
        .MEM_IDATA(mem_idata), .MEM_ODATA_SELECT(mem_sel), .MEM_ODATA(mem_odata)
    );

    sram64kb_ctrl #(.ACCESS_WAIT(3)) dut3 (
        .CLK(clk), .RST(rst), .REQ_VALID(b_valid), .REQ_READY(b_ready),
        .REQ_WRITE(b_write), .REQ_ADDR(b_addr), .REQ_WDATA(b_wdata),
        .RSP_VALID(b_rsp), .RSP_RDATA(b_rdata), .MEM_ADDR(b_maddr),
        .MEM_CE(b_ce), .MEM_WEB(b_web), .MEM_OEB(b_oeb), .MEM_CSB(b_csb),
        .MEM_IDATA(b_idata), .MEM_ODATA_SELECT(b_sel), .MEM_ODATA(b_odata)
    );

    // Array models: write on CE rising edge, read mux gated by the selected bank's enables
    logic [7:0] mem1 [65536];
    logic [7:0] mem3 [65536];

    always @(posedge mem_ce)
        if (!mem_web && !mem_csb[mem_sel]) mem1[{mem_sel, mem_addr}] = mem_idata;
    always @(posedge b_ce)
        if (!b_web && !b_csb[b_sel]) mem3[{b_sel, b_maddr}] = b_idata;

    assign mem_odata = (!mem_oeb[mem_sel] && !mem_csb[mem_sel]) ? mem1[{mem_sel, mem_addr}] : 8'h00;
    assign b_odata   = (!b_oeb[b_sel] && !b_csb[b_sel]) ? mem3[{b_sel, b_maddr}] : 8'h00;

    int vecs = 0;
    int errs = 0;
    logic mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Select-safety rules checked every cycle outside reset
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            chk("one_csb_low", 64'($countones(~mem_csb) <= 1), 64'(1));
            chk("one_oeb_low", 64'($countones(~mem_oeb) <= 1), 64'(1));
            chk("oeb_vs_web", 64'(!(!mem_web && (mem_oeb != '1))), 64'(1));
        end
    end

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [5:0]  sel;
        logic [9:0]  row;
        logic [63:0] csb;
        logic [63:0] oeb;
        logic [7:0]  rdata;
    } vec_t;

    vec_t tbl [9];

    task automatic access(input logic wr, input logic [15:0] addr, input logic [7:0] wd,
                          output int lat, output logic [5:0] sel, output logic [9:0] row,
                          output logic [63:0] csb, output logic [63:0] oeb, output logic web,
                          output logic [7:0] idata, output logic ce1, output logic ce2);
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
        chk("ready_before_accept", 64'(req_ready), 64'(1));
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        sel = mem_sel; row = mem_addr; csb = mem_csb; oeb = mem_oeb;
        web = mem_web; idata = mem_idata; ce1 = mem_ce;
        @(negedge clk);
        ce2 = mem_ce;
        lat = -1;
        for (int n = 3; n <= 20; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    int          lat;
    logic [5:0]  s_sel;
    logic [9:0]  s_row;
    logic [63:0] s_csb, s_oeb;
    logic        s_web, s_ce1, s_ce2;
    logic [7:0]  s_idata;
    int          acc [3];
    int          nacc, npulse, nce, rsp_at;

    initial begin
        tbl[0] = '{1'b1, 16'h0000, 8'hA5, 6'd0,  10'd0,    64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00};
        tbl[1] = '{1'b0, 16'h0000, 8'h00, 6'd0,  10'd0,    64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE, 8'hA5};
        tbl[2] = '{1'b1, 16'hFFFF, 8'h3C, 6'd63, 10'd1023, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 8'hA5};
        tbl[3] = '{1'b1, 16'h03FF, 8'hC3, 6'd0,  10'd1023, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 8'hA5};
        tbl[4] = '{1'b0, 16'hFFFF, 8'h00, 6'd63, 10'd1023, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 8'h3C};
        tbl[5] = '{1'b0, 16'h03FF, 8'h00, 6'd0,  10'd1023, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE, 8'hC3};
        tbl[6] = '{1'b1, 16'h0400, 8'h77, 6'd1,  10'd0,    64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 8'hC3};
        tbl[7] = '{1'b0, 16'h0400, 8'h00, 6'd1,  10'd0,    64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFD, 8'h77};
        tbl[8] = '{1'b1, 16'h0010, 8'h11, 6'd0,  10'h010,  64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 8'h77};

        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        b_valid = 1'b0; b_write = 1'b0; b_addr = '0; b_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_csb", mem_csb, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_oeb", mem_oeb, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_web", 64'(mem_web), 64'(1));
        chk("rst_ce", 64'(mem_ce), 64'(0));
        chk("rst_addr", 64'(mem_addr), 64'(0));
        chk("rst_sel", 64'(mem_sel), 64'(0));
        chk("rst_idata", 64'(mem_idata), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rdata", 64'(rsp_rdata), 64'(0));
        chk("rst_ready_low", 64'(req_ready), 64'(0));
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 64'(req_ready), 64'(1));

        // Table-driven single accesses
        for (int i = 0; i < 9; i++) begin
            access(tbl[i].wr, tbl[i].addr, tbl[i].wdata, lat, s_sel, s_row, s_csb, s_oeb,
                   s_web, s_idata, s_ce1, s_ce2);
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'(4));
            chk($sformatf("v%0d_sel", i), 64'(s_sel), 64'(tbl[i].sel));
            chk($sformatf("v%0d_row", i), 64'(s_row), 64'(tbl[i].row));
            chk($sformatf("v%0d_csb", i), s_csb, tbl[i].csb);
            chk($sformatf("v%0d_oeb", i), s_oeb, tbl[i].oeb);
            chk($sformatf("v%0d_web", i), 64'(s_web), 64'(!tbl[i].wr));
            if (tbl[i].wr) chk($sformatf("v%0d_idata", i), 64'(s_idata), 64'(tbl[i].wdata));
            chk($sformatf("v%0d_ce_setup", i), 64'(s_ce1), 64'(0));
            chk($sformatf("v%0d_ce_strobe", i), 64'(s_ce2), 64'(1));
            chk($sformatf("v%0d_rdata", i), 64'(rsp_rdata), 64'(tbl[i].rdata));
            @(negedge clk);
            chk($sformatf("v%0d_rsp_one_cycle", i), 64'(rsp_valid), 64'(0));
            chk($sformatf("v%0d_ready_idle", i), 64'(req_ready), 64'(1));
        end

        // Back-to-back reads with REQ_VALID held high
        nacc = 0; npulse = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0000;
        for (int c = 0; c < 30; c++) begin
            if (c > 0) @(negedge clk);
            if (rsp_valid) npulse++;
            if (nacc > 0 && nacc < 3 && (c - acc[nacc-1]) >= 1 && (c - acc[nacc-1]) <= 4)
                chk("b2b_ready_low", 64'(req_ready), 64'(0));
            if (req_valid && req_ready && nacc < 3) begin
                acc[nacc] = c;
                nacc++;
                if (nacc == 3) begin
                    @(posedge clk);
                    #1 req_valid = 1'b0;
                end
            end
        end
        chk("b2b_accepts", 64'(nacc), 64'(3));
        chk("b2b_space01", 64'(acc[1] - acc[0]), 64'(5));
        chk("b2b_space12", 64'(acc[2] - acc[1]), 64'(5));
        chk("b2b_pulses", 64'(npulse), 64'(3));
        chk("b2b_rdata", 64'(rsp_rdata), 64'(8'hA5));

        // Reset during the WAIT cycle of a read
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'hFFFF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_csb", mem_csb, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("abort_oeb", mem_oeb, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("abort_ce", 64'(mem_ce), 64'(0));
        chk("abort_rsp", 64'(rsp_valid), 64'(0));
        chk("abort_rdata", 64'(rsp_rdata), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("abort_rsp_after", 64'(rsp_valid), 64'(0));
        chk("abort_ready", 64'(req_ready), 64'(1));

        // Write aborted in SETUP must not reach the array
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0010; req_wdata = 8'hEE;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("wabort_ce", 64'(mem_ce), 64'(0));
        rst = 1'b0;
        access(1'b0, 16'h0010, 8'h00, lat, s_sel, s_row, s_csb, s_oeb, s_web, s_idata, s_ce1, s_ce2);
        chk("wabort_latency", 64'(lat), 64'(4));
        chk("wabort_rdata", 64'(rsp_rdata), 64'(8'h11));

        // ACCESS_WAIT = 3 instance: store then read back
        @(negedge clk);
        b_valid = 1'b1; b_write = 1'b1; b_addr = 16'h1234; b_wdata = 8'h5A;
        chk("aw3_ready_wr", 64'(b_ready), 64'(1));
        @(posedge clk);
        #1 b_valid = 1'b0;
        repeat (10) @(negedge clk);
        b_write = 1'b0; b_valid = 1'b1;
        chk("aw3_ready_rd", 64'(b_ready), 64'(1));
        @(posedge clk);
        #1 b_valid = 1'b0;
        nce = 0; rsp_at = -1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (b_ce) nce++;
            if (b_rsp && rsp_at < 0) rsp_at = n;
        end
        chk("aw3_ce_cycles", 64'(nce), 64'(1));
        chk("aw3_latency", 64'(rsp_at), 64'(6));
        chk("aw3_rdata", 64'(b_rdata), 64'(8'h5A));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
